// File: rtl/kbd_move_decoder_if.sv
// Scan-code byte stream from the PS/2 receiver: one rx_valid strobe per byte, no back-pressure.
interface kbd_move_decoder_if;
   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (output rx_data, rx_valid);
   modport slave  (input  rx_data, rx_valid);
endinterface

// File: rtl/kbd_move_decoder.sv
// Scan set 2 bytes -> held left/right/jump levels; E0/F0 prefixes, Pause swallowed, WASD keys under KBD_WASD_EN.
// Latency 1 clk from final byte to registered outputs; no back-pressure, every rx_valid strobe is consumed.
module kbd_move_decoder #(
   parameter int PREFIX_TIMEOUT = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   kbd_move_decoder_if.slave rx,
   output logic              left,
   output logic              right,
   output logic              jump,
   output logic              seq_err
);
`ifdef KBD_WASD_EN
   localparam int NKEY = 7;
   localparam int K_A  = 4;
   localparam int K_D  = 5;
   localparam int K_W  = 6;
`else
   localparam int NKEY = 4;
`endif
   localparam int K_ARR_L = 0;
   localparam int K_ARR_R = 1;
   localparam int K_ARR_U = 2;
   localparam int K_SPACE = 3;

   localparam logic [19:0] TMO = 20'(PREFIX_TIMEOUT);

   typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

   state_t          state;
   logic [2:0]      skip;
   logic [19:0]     cnt;
   logic [NKEY-1:0] held;
   logic [NKEY-1:0] held_nxt;
   logic            left_nxt;
   logic            right_nxt;
   logic            jump_nxt;

   function automatic logic [NKEY-1:0] key_mask(input logic [7:0] code, input logic ext);
      logic [NKEY-1:0] m;
      m = '0;
      if (ext) begin
         case (code)
            8'h6B:   m[K_ARR_L] = 1'b1;
            8'h74:   m[K_ARR_R] = 1'b1;
            8'h75:   m[K_ARR_U] = 1'b1;
            default: m = '0;
         endcase
      end else begin
         case (code)
            8'h29:   m[K_SPACE] = 1'b1;
`ifdef KBD_WASD_EN
            8'h1C:   m[K_A] = 1'b1;
            8'h23:   m[K_D] = 1'b1;
            8'h1D:   m[K_W] = 1'b1;
`endif
            default: m = '0;
         endcase
      end
      return m;
   endfunction

   function automatic logic is_err(input logic [7:0] code);
      return (code == 8'h00) || (code == 8'hFF) || (code == 8'hAA) ||
             (code == 8'hFE) || (code == 8'hEE);
   endfunction

   // Prefix bytes, fake shifts and error codes never hit key_mask, so no extra filtering is needed here.
   always_comb begin
      held_nxt = held;
      if (rx.rx_valid) begin
         case (state)
            IDLE:    held_nxt = held |  key_mask(rx.rx_data, 1'b0);
            EXT:     held_nxt = held |  key_mask(rx.rx_data, 1'b1);
            BRK:     held_nxt = held & ~key_mask(rx.rx_data, 1'b0);
            EXT_BRK: held_nxt = held & ~key_mask(rx.rx_data, 1'b1);
            default: held_nxt = held;
         endcase
      end
   end

   always_comb begin
      left_nxt  = held_nxt[K_ARR_L];
      right_nxt = held_nxt[K_ARR_R];
      jump_nxt  = held_nxt[K_ARR_U] | held_nxt[K_SPACE];
`ifdef KBD_WASD_EN
      left_nxt  = left_nxt  | held_nxt[K_A];
      right_nxt = right_nxt | held_nxt[K_D];
      jump_nxt  = jump_nxt  | held_nxt[K_W];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         skip    <= '0;
         cnt     <= '0;
         held    <= '0;
         left    <= 1'b0;
         right   <= 1'b0;
         jump    <= 1'b0;
         seq_err <= 1'b0;
      end else begin
         held    <= held_nxt;
         left    <= left_nxt;
         right   <= right_nxt;
         jump    <= jump_nxt;
         seq_err <= 1'b0;
         if (rx.rx_valid) begin
            cnt <= '0;
            case (state)
               IDLE: begin
                  if (rx.rx_data == 8'hE0) begin
                     state <= EXT;
                  end else if (rx.rx_data == 8'hF0) begin
                     state <= BRK;
                  end else if (rx.rx_data == 8'hE1) begin
                     state <= PAUSE;
                     skip  <= 3'd7;
                  end
               end
               EXT: begin
                  if (is_err(rx.rx_data)) begin
                     state <= IDLE;
                  end else if (rx.rx_data == 8'hF0) begin
                     state <= EXT_BRK;
                  end else if (rx.rx_data != 8'hE0) begin
                     state <= IDLE;
                  end
               end
               BRK: begin
                  if (is_err(rx.rx_data) ||
                      ((rx.rx_data != 8'hF0) && (rx.rx_data != 8'hE0))) begin
                     state <= IDLE;
                  end
               end
               EXT_BRK: state <= IDLE;
               PAUSE: begin
                  if (is_err(rx.rx_data) || (skip <= 3'd1)) begin
                     state <= IDLE;
                     skip  <= '0;
                  end else begin
                     skip <= skip - 3'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            // A byte on the timeout cycle takes the branch above, so it always wins.
            if (cnt == TMO) begin
               state   <= IDLE;
               skip    <= '0;
               cnt     <= '0;
               seq_err <= 1'b1;
            end else begin
               cnt <= cnt + 20'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_kbd_move_decoder.sv
// Directed bench for kbd_move_decoder: byte sequences with hand-computed left/right/jump levels.
module tb_kbd_move_decoder;
   logic clk = 1'b0;
   logic rst;
   logic left, right, jump, seq_err;
   int   n_checks = 0;
   int   n_fail   = 0;

   kbd_move_decoder_if rx_if();

   kbd_move_decoder #(.PREFIX_TIMEOUT(100)) dut (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx_if),
      .left    (left),
      .right   (right),
      .jump    (jump),
      .seq_err (seq_err)
   );

   always #5 clk = ~clk;

   // Called at a negedge; byte is sampled on the next posedge, outputs read at the following negedge.
   task automatic send(input logic [7:0] v);
      rx_if.rx_data  = v;
      rx_if.rx_valid = 1'b1;
      @(negedge clk);
      rx_if.rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      rx_if.rx_data  = 8'h29;
      rx_if.rx_valid = 1'b1;
      repeat (3) @(negedge clk);
      rst            = 1'b0;
      rx_if.rx_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({left, right, jump} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_levels: got %b want 000", {left, right, jump});
      end
      n_checks++;
      if (seq_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_seq_err: got %b want 0", seq_err);
      end
   endtask

   task automatic test_left();
      logic [7:0] b [5];
      logic [2:0] e [5];
      b = '{8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h6B};
      e = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b000};
      for (int i = 0; i < 5; i++) begin
         send(b[i]);
         n_checks++;
         if ({left, right, jump} !== e[i]) begin
            n_fail++;
            $display("FAIL left_seq[%0d]: got %b want %b", i, {left, right, jump}, e[i]);
         end
      end
   endtask

   task automatic test_jump();
      logic [7:0] b [8];
      logic [2:0] e [8];
      b = '{8'h29, 8'hE0, 8'h75, 8'hF0, 8'h29, 8'hE0, 8'hF0, 8'h75};
      e = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
      for (int i = 0; i < 8; i++) begin
         send(b[i]);
         n_checks++;
         if ({left, right, jump} !== e[i]) begin
            n_fail++;
            $display("FAIL jump_seq[%0d]: got %b want %b", i, {left, right, jump}, e[i]);
         end
      end
   endtask

   task automatic test_both();
      logic [7:0] b [10];
      logic [2:0] e [10];
      b = '{8'hE0, 8'h74, 8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h74, 8'hE0, 8'hF0, 8'h6B};
      e = '{3'b000, 3'b010, 3'b010, 3'b110, 3'b110, 3'b110, 3'b100, 3'b100, 3'b100, 3'b000};
      for (int i = 0; i < 10; i++) begin
         send(b[i]);
         n_checks++;
         if ({left, right, jump} !== e[i]) begin
            n_fail++;
            $display("FAIL both_seq[%0d]: got %b want %b", i, {left, right, jump}, e[i]);
         end
      end
   endtask

   task automatic test_pause();
      logic [7:0] b [13];
      logic [2:0] e [13];
      b = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77,
            8'hE0, 8'h74, 8'hE0, 8'hF0, 8'h74};
      e = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
            3'b000, 3'b010, 3'b010, 3'b010, 3'b000};
      for (int i = 0; i < 13; i++) begin
         send(b[i]);
         n_checks++;
         if ({left, right, jump} !== e[i]) begin
            n_fail++;
            $display("FAIL pause_seq[%0d]: got %b want %b", i, {left, right, jump}, e[i]);
         end
      end
   endtask

   task automatic test_prefix_repeat();
      logic [7:0] b [10];
      logic [2:0] e [10];
      b = '{8'h29, 8'hF0, 8'hF0, 8'h29, 8'hE0, 8'hE0, 8'h74, 8'hE0, 8'hF0, 8'h74};
      e = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 3'b000};
      for (int i = 0; i < 10; i++) begin
         send(b[i]);
         n_checks++;
         if ({left, right, jump} !== e[i]) begin
            n_fail++;
            $display("FAIL prefix_repeat[%0d]: got %b want %b", i, {left, right, jump}, e[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int first;
      int pulses;
      first  = -1;
      pulses = 0;
      send(8'h29);
      send(8'hE0);
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (seq_err === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
      n_checks++;
      if (first !== 101) begin
         n_fail++;
         $display("FAIL timeout_cycle: got %0d want 101", first);
      end
      n_checks++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL timeout_pulses: got %0d want 1", pulses);
      end
      n_checks++;
      if ({left, right, jump} !== 3'b001) begin
         n_fail++;
         $display("FAIL timeout_held: got %b want 001", {left, right, jump});
      end
      send(8'h6B);
      n_checks++;
      if ({left, right, jump} !== 3'b001) begin
         n_fail++;
         $display("FAIL timeout_then_6b: got %b want 001", {left, right, jump});
      end
      send(8'hF0);
      send(8'h29);
      n_checks++;
      if ({left, right, jump} !== 3'b000) begin
         n_fail++;
         $display("FAIL timeout_cleanup: got %b want 000", {left, right, jump});
      end
   endtask

   task automatic test_timeout_precedence();
      int pulses;
      pulses = 0;
      send(8'hE0);
      repeat (100) @(negedge clk);
      send(8'h74);
      if (seq_err === 1'b1) pulses++;
      n_checks++;
      if ({left, right, jump} !== 3'b010) begin
         n_fail++;
         $display("FAIL precedence_make: got %b want 010", {left, right, jump});
      end
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (seq_err === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL precedence_seq_err: got %0d pulses want 0", pulses);
      end
      send(8'hE0);
      send(8'hF0);
      send(8'h74);
      n_checks++;
      if ({left, right, jump} !== 3'b000) begin
         n_fail++;
         $display("FAIL precedence_cleanup: got %b want 000", {left, right, jump});
      end
   endtask

   task automatic test_reset_mid_sequence();
      send(8'h29);
      send(8'hE0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({left, right, jump} !== 3'b000) begin
         n_fail++;
         $display("FAIL midreset_levels: got %b want 000", {left, right, jump});
      end
      send(8'h74);
      n_checks++;
      if ({left, right, jump} !== 3'b000) begin
         n_fail++;
         $display("FAIL midreset_state_idle: got %b want 000", {left, right, jump});
      end
   endtask

   task automatic test_wasd();
`ifdef KBD_WASD_EN
      logic [7:0] b [14];
      logic [2:0] e [14];
      b = '{8'h1C, 8'hE0, 8'h6B, 8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h6B,
            8'h23, 8'h1D, 8'hF0, 8'h23, 8'hF0, 8'h1D};
      e = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
            3'b010, 3'b011, 3'b011, 3'b001, 3'b001, 3'b000};
      for (int i = 0; i < 14; i++) begin
         send(b[i]);
         n_checks++;
         if ({left, right, jump} !== e[i]) begin
            n_fail++;
            $display("FAIL wasd_seq[%0d]: got %b want %b", i, {left, right, jump}, e[i]);
         end
      end
`else
      logic [7:0] b [3];
      b = '{8'h1C, 8'h23, 8'h1D};
      for (int i = 0; i < 3; i++) begin
         send(b[i]);
         n_checks++;
         if ({left, right, jump} !== 3'b000) begin
            n_fail++;
            $display("FAIL wasd_unmapped[%0d]: got %b want 000", i, {left, right, jump});
         end
      end
`endif
   endtask

   initial begin
      rx_if.rx_data  = 8'h00;
      rx_if.rx_valid = 1'b0;
      rst            = 1'b1;
      @(negedge clk);
      test_reset();
      test_left();
      test_jump();
      test_both();
      test_pause();
      test_prefix_repeat();
      test_timeout();
      test_timeout_precedence();
      test_reset_mid_sequence();
      test_wasd();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/kbd_move_decoder.md
# kbd_move_decoder

Converts the byte stream from the PS/2 receiver (scan code set 2) into held-key levels `left`, `right`, `jump` that drive the player movement controller. Tracks `E0`/`F0` prefix sequences, maintains per-key pressed/released state across make/break codes, and swallows the 8-byte Pause sequence. Sits between the PS/2 byte receiver and the movement control logic, in the same clock domain as both.

## Interface
Parameters:
- `PREFIX_TIMEOUT`, 1_000_000, clock cycles a prefix state may wait for its next byte before abandoning the sequence.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received scan-code byte; valid only when `rx_valid` = 1.
- `rx_valid`  in  1  single-cycle strobe, one per received byte; no back-pressure.
- `left`  out  1  level, 1 while a left key is held.
- `right`  out  1  level, 1 while a right key is held.
- `jump`  out  1  level, 1 while a jump key is held.
- `seq_err`  out  1  single-cycle pulse on prefix timeout.

## Operation
- Key map, base set: Left arrow `E0 6B`, Right arrow `E0 74`, Up arrow `E0 75` -> jump, Space `29` -> jump.
- Make = code with optional `E0`. Break = `F0` before the code, i.e. `F0 xx` or `E0 F0 xx`.
- One held bit per physical key: `arr_l`, `arr_r`, `arr_u`, `space`, plus the WASD bits when configured. Make sets the bit. Break clears it.
- Outputs are the OR of all held bits mapped to that output.
- Both left and right held gives `left` = `right` = 1. Conflict resolution belongs to the consumer.
- Typematic repeats of a make code re-set an already-set bit; this is harmless.
- Unmapped codes, `FA` (ack), `AA` (BAT pass), `EE`, `FE`, and `00`/`FF` (errors) cause no bit change.
- When `00`/`FF`/`AA`/`FE`/`EE` arrives in a prefix state, it returns the FSM to IDLE.
- FSM states and transitions:
  - IDLE: `E0` -> EXT; `F0` -> BRK; `E1` -> PAUSE with skip = 7; mapped code -> set bit, stay.
  - EXT: `F0` -> EXT_BRK; `E0` -> stay; `12`/`59` (fake shift) -> IDLE, ignored; other byte -> apply extended make, IDLE.
  - BRK: any byte -> apply base break, IDLE. A `F0` or `E0` arriving here is ignored and the state stays BRK.
  - EXT_BRK: any byte -> apply extended break, IDLE.
  - PAUSE: decrement skip on each byte; -> IDLE after the 7th byte. No bit change.
- Prefix timeout: a 20-bit idle counter runs in EXT, BRK, EXT_BRK and PAUSE. It clears on every `rx_valid` and holds at 0 in IDLE. When it reaches `PREFIX_TIMEOUT`:
  - the FSM goes to IDLE;
  - `seq_err` pulses for 1 cycle;
  - held bits are unchanged.
- Reset mid-sequence: all held bits clear, state goes to IDLE, and the counter goes to 0. A byte presented with `rst` = 1 is discarded.

## Timing
- Reset values: `left` = `right` = `jump` = 0, `seq_err` = 0, state IDLE, skip = 0, counter = 0.
- All outputs are registered.
- A byte sampled with `rx_valid` = 1 on edge N affects the outputs from edge N onward, i.e. they are visible in cycle N+1.
- Latency is 1 clock from the final byte of a sequence to the output change.
- Back-to-back `rx_valid` on consecutive cycles must be handled with no loss.
- `seq_err` asserts in the cycle after the counter equals `PREFIX_TIMEOUT`.
- A byte arriving on the same cycle as the timeout takes precedence: it is processed normally and no `seq_err` is raised.

## Configuration
- `KBD_WASD_EN` defined:
  - adds held bits for A (`1C`) -> left, D (`23`) -> right, W (`1D`) -> jump;
  - these keys are non-extended; make and break follow the base rules;
  - each output is the OR of its arrow, letter and (for jump) Space bits.
- Not defined: `1C`/`23`/`1D` are unmapped and the WASD bits are not synthesised.

## Test plan
- Reset, then bytes `E0 6B` -> `left` = 1 one cycle after the `6B` strobe. Then `E0 F0 6B` -> `left` = 0. `right`/`jump` stay 0 throughout.
- Bytes `29`, `E0 75`, then `F0 29` -> `jump` stays 1, because Up is still held. Then `E0 F0 75` -> `jump` = 0.
- `E0 74`, then `E0 6B` -> `left` = `right` = 1. Then `E0 F0 74` -> `right` = 0 and `left` = 1.
- Pause sequence `E1 14 77 E1 F0 14 F0 77`, then `E0 74` -> no output change during the pause bytes, then `right` = 1. The embedded `F0` must not cause a break.
- Single `E0`, then no byte for `PREFIX_TIMEOUT` (bench uses 100) cycles -> one-cycle `seq_err`. A following `6B` alone is unmapped, so `left` stays 0.
- With `KBD_WASD_EN`: `1C`, then `E0 6B`, then `F0 1C` -> `left` stays 1. Then `E0 F0 6B` -> `left` = 0. Without the macro, `1C` leaves `left` = 0.
